// File: rtl/mm_bus_pkg.sv
// Shared types and requester IDs for the memory bus arbitration slice.
package mm_bus_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_HOLD} arb_state_t;

  localparam int unsigned NUM_BUS_REQ = 4;

  localparam int unsigned REQ_ITLB   = 0;
  localparam int unsigned REQ_ICACHE = 1;
  localparam int unsigned REQ_DTLB   = 2;
  localparam int unsigned REQ_DCACHE = 3;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: first set request at or after ptr, wrapping.
module rr_priority_picker
  import mm_bus_pkg::*;
#(
  parameter int unsigned NUM_REQ  = NUM_BUS_REQ,
  parameter int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [ID_WIDTH-1:0] winner,
  output logic                valid
);

  logic [ID_WIDTH-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = ID_WIDTH'((32'(ptr) + i) % NUM_REQ);
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin owner arbitration for the shared memory bus; owner_id drives the bus mux select.
module mem_bus_arbiter
  import mm_bus_pkg::*;
#(
  parameter int unsigned NUM_REQ       = NUM_BUS_REQ,
  parameter int unsigned ID_WIDTH      = $clog2(NUM_REQ),
  parameter int unsigned GRANT_TIMEOUT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQ-1:0]  req_reqcyc,
  input  logic [NUM_REQ-1:0]  req_busy,
  output logic [NUM_REQ-1:0]  grant,
  output logic                owner_valid,
  output logic [ID_WIDTH-1:0] owner_id,
  output logic                bus_idle,
  output logic                protocol_err
);

  localparam int unsigned CNT_W = $clog2(GRANT_TIMEOUT + 1);

  arb_state_t          state_q, state_d;
  logic [NUM_REQ-1:0]  grant_d;
  logic [ID_WIDTH-1:0] owner_id_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0] pick_id, next_ptr;
  logic                pick_valid;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                perr_d;
  logic                owner_busy, owner_req, release_own;

  rr_priority_picker #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_picker (
    .req    (req_reqcyc),
    .ptr    (rr_ptr_q),
    .winner (pick_id),
    .valid  (pick_valid)
  );

  assign owner_busy = req_busy[owner_id];
  assign owner_req  = req_reqcyc[owner_id];
  // Next search starts just past the releasing owner so it cannot win again while others wait.
  assign next_ptr   = (owner_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : owner_id + ID_WIDTH'(1);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant;
    owner_id_d  = owner_id;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    release_own = 1'b0;
    perr_d      = (state_q == ARB_IDLE) ? (|req_busy) : (|(req_busy & ~grant));

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d    = ARB_GRANT;
          grant_d    = NUM_REQ'(1) << pick_id;
          owner_id_d = pick_id;
          cnt_d      = '0;
        end
      end
      ARB_GRANT: begin
        // A claim on the timeout edge still wins.
        if (owner_busy) begin
          state_d = ARB_HOLD;
        end else if (!owner_req || (cnt_q == CNT_W'(GRANT_TIMEOUT - 1))) begin
          release_own = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ARB_HOLD: begin
        if (!owner_busy) release_own = 1'b1;
      end
      default: state_d = ARB_IDLE;
    endcase

    if (release_own) begin
      state_d    = ARB_IDLE;
      grant_d    = '0;
      owner_id_d = '0;
      rr_ptr_d   = next_ptr;
      cnt_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      grant        <= '0;
      owner_valid  <= 1'b0;
      owner_id     <= '0;
      bus_idle     <= 1'b1;
      protocol_err <= 1'b0;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant        <= grant_d;
      owner_valid  <= (state_d != ARB_IDLE);
      owner_id     <= owner_id_d;
      bus_idle     <= (state_d == ARB_IDLE);
      protocol_err <= perr_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus randomized traffic against an ownership model.
module tb_mem_bus_arbiter;

  localparam int TIMEOUT = 4;

  logic       clk;
  logic       reset;
  logic [3:0] req_reqcyc;
  logic [3:0] req_busy;
  logic [3:0] grant;
  logic       owner_valid;
  logic [1:0] owner_id;
  logic       bus_idle;
  logic       protocol_err;

  mem_bus_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .req_reqcyc   (req_reqcyc),
    .req_busy     (req_busy),
    .grant        (grant),
    .owner_valid  (owner_valid),
    .owner_id     (owner_id),
    .bus_idle     (bus_idle),
    .protocol_err (protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: who owns the bus, whether it has claimed it, how long the grant has waited.
  int         m_owner = -1;
  bit         m_claim = 0;
  int         m_age   = 0;
  int         m_rr    = 0;
  logic [3:0] exp_grant = 4'b0;
  logic       exp_valid = 1'b0;
  logic [1:0] exp_id    = 2'd0;
  logic       exp_idle  = 1'b1;
  logic       exp_perr  = 1'b0;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, want);
    end
  endtask

  task automatic model_step(input logic [3:0] rq, input logic [3:0] bz, input bit rst);
    logic [3:0] own_mask;
    int         c;
    bit         rel;
    own_mask = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    exp_perr = (m_owner < 0) ? (bz != 4'b0) : ((bz & ~own_mask) != 4'b0);
    rel = 0;
    if (rst) begin
      m_owner = -1; m_claim = 0; m_age = 0; m_rr = 0; exp_perr = 1'b0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        c = (m_rr + k) % 4;
        if (m_owner < 0 && rq[c]) begin
          m_owner = c; m_claim = 0; m_age = 0;
        end
      end
    end else if (!m_claim) begin
      if (bz[m_owner]) m_claim = 1;
      else begin
        m_age++;
        if (!rq[m_owner] || m_age >= TIMEOUT) rel = 1;
      end
    end else if (!bz[m_owner]) begin
      rel = 1;
    end
    if (rel) begin
      m_rr = (m_owner + 1) % 4;
      m_owner = -1;
    end
    exp_grant = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    exp_valid = (m_owner >= 0);
    exp_id    = (m_owner < 0) ? 2'd0 : 2'(m_owner);
    exp_idle  = (m_owner < 0);
  endtask

  task automatic cyc(input logic [3:0] rq, input logic [3:0] bz, input bit rst);
    req_reqcyc = rq;
    req_busy   = bz;
    reset      = rst;
    @(posedge clk);
    model_step(rq, bz, rst);
    @(negedge clk);
  endtask

  // Every cycle, all outputs against the model.
  always @(negedge clk) begin
    check("grant",        int'(grant),        int'(exp_grant));
    check("owner_valid",  int'(owner_valid),  int'(exp_valid));
    check("owner_id",     int'(owner_id),     int'(exp_id));
    check("bus_idle",     int'(bus_idle),     int'(exp_idle));
    check("protocol_err", int'(protocol_err), int'(exp_perr));
  end

  initial begin
    logic [3:0] rq, bz;
    req_reqcyc = 4'b0;
    req_busy   = 4'b0;
    reset      = 1'b1;

    cyc(4'b0000, 4'b0000, 1);
    cyc(4'b0000, 4'b0000, 1);
    check("lit_reset_grant", int'(grant), 0);
    check("lit_reset_idle",  int'(bus_idle), 1);

    // Single request, busy held four cycles.
    cyc(4'b0100, 4'b0000, 0);
    check("lit_single_grant", int'(grant), 4);
    check("lit_single_id",    int'(owner_id), 2);
    for (int i = 0; i < 4; i++) cyc(4'b0100, 4'b0100, 0);
    check("lit_single_hold", int'(grant), 4);
    cyc(4'b0000, 4'b0000, 0);
    check("lit_single_release", int'(grant), 0);
    check("lit_single_idle",    int'(bus_idle), 1);

    // All four requesting: strict rotation with a gap cycle between owners.
    cyc(4'b0000, 4'b0000, 1);
    for (int g = 0; g < 5; g++) begin
      cyc(4'b1111, 4'b0000, 0);
      check("lit_rr_order", int'(owner_id), g % 4);
      for (int i = 0; i < 3; i++) cyc(4'b1111, 4'(1 << (g % 4)), 0);
      cyc(4'b1111, 4'b0000, 0);
      check("lit_rr_gap", int'(grant), 0);
    end

    // Unclaimed grant times out after four visible cycles; requester 3 follows.
    cyc(4'b0000, 4'b0000, 1);
    cyc(4'b0010, 4'b0000, 0);
    check("lit_to_grant", int'(grant), 2);
    for (int i = 0; i < 3; i++) begin
      cyc(4'b1010, 4'b0000, 0);
      check("lit_to_still", int'(grant), 2);
    end
    cyc(4'b1010, 4'b0000, 0);
    check("lit_to_revoked", int'(grant), 0);
    cyc(4'b1010, 4'b0000, 0);
    check("lit_to_next", int'(grant), 8);

    // Early withdrawal advances the pointer past requester 0.
    cyc(4'b0000, 4'b0000, 1);
    cyc(4'b0001, 4'b0000, 0);
    check("lit_wd_grant", int'(grant), 1);
    cyc(4'b0000, 4'b0000, 0);
    check("lit_wd_clear", int'(grant), 0);
    cyc(4'b0011, 4'b0000, 0);
    check("lit_wd_ptr", int'(grant), 2);

    // Reset during HOLD.
    cyc(4'b0000, 4'b0000, 1);
    cyc(4'b1000, 4'b0000, 0);
    cyc(4'b1010, 4'b1000, 0);
    cyc(4'b1010, 4'b1000, 1);
    check("lit_rst_grant", int'(grant), 0);
    check("lit_rst_valid", int'(owner_valid), 0);
    check("lit_rst_idle",  int'(bus_idle), 1);
    cyc(4'b1010, 4'b0000, 0);
    check("lit_rst_regrant", int'(grant), 2);

    // Foreign busy while requester 2 holds.
    cyc(4'b0000, 4'b0000, 1);
    cyc(4'b0100, 4'b0000, 0);
    cyc(4'b0100, 4'b0100, 0);
    cyc(4'b0100, 4'b0101, 0);
    check("lit_err_pulse", int'(protocol_err), 1);
    check("lit_err_grant", int'(grant), 4);
    cyc(4'b0100, 4'b0100, 0);
    check("lit_err_clear", int'(protocol_err), 0);
    check("lit_err_keep",  int'(grant), 4);

    // Randomized traffic; owners mostly claim, with occasional stray busy and resets.
    cyc(4'b0000, 4'b0000, 1);
    for (int n = 0; n < 3000; n++) begin
      rq = 4'($urandom);
      bz = 4'b0;
      if (m_owner >= 0 && ($urandom % 4) != 0) bz = 4'(1 << m_owner);
      if (($urandom % 16) == 0) bz = bz | 4'(1 << ($urandom % 4));
      cyc(rq, bz, ($urandom % 200) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
